bf16_mul_arbiter: RTL and testbench

//  Round-robin scheduler sharing one BF16 multiplier among N_REQ requesters.

---
 rtl/bf16_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/bf16_mul_arbiter.sv | 141 ++++++++++++++
 tb/tb_bf16_mul_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared BF16 constants, flag bit positions and the scheduler state type.
package bf16_pkg;

    localparam int unsigned BF16_W = 16;
    localparam int unsigned FLAG_W = 7;

    // Flag vector order: {zero, underflow, overflow, qNaN, sNaN, pos_inf, neg_inf}
    localparam int unsigned FLG_ZERO = 6;
    localparam int unsigned FLG_UNF  = 5;
    localparam int unsigned FLG_OVF  = 4;
    localparam int unsigned FLG_QNAN = 3;
    localparam int unsigned FLG_SNAN = 2;
    localparam int unsigned FLG_PINF = 1;
    localparam int unsigned FLG_NINF = 0;

    localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FC0;
    localparam logic [BF16_W-1:0] BF16_SNAN = 16'h7FA0;
    localparam logic [BF16_W-1:0] BF16_PINF = 16'h7F80;
    localparam logic [BF16_W-1:0] BF16_NINF = 16'hFF80;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer moves just past the winner only when a grant is taken.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid_i,
    input  logic            advance_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] grant_id_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    // Scan from the pointer, wrapping modulo N, and take the first valid index.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req_valid_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = ID_W'(idx);
            end
        end
    end

    // Next pointer is one past the winner, wrapping at N.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            if (int'(grant_id_o) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id_o + ID_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bf16_mul_arbiter.sv
// Shares one BF16 multiplier among N_REQ requesters: grant, hold operands for
// MUL_LAT cycles, register product and flags, return them on a valid/ready channel.
module bf16_mul_arbiter
    import bf16_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*BF16_W-1:0] req_a,
    input  logic [N_REQ*BF16_W-1:0] req_b,
    output logic [BF16_W-1:0]       mul_a,
    output logic [BF16_W-1:0]       mul_b,
    input  logic [BF16_W-1:0]       mul_result,
    input  logic [FLAG_W-1:0]       mul_flags,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [BF16_W-1:0]       rsp_result,
    output logic [FLAG_W-1:0]       rsp_flags,
    output logic [FLAG_W-1:0]       sticky_flags,
    input  logic                    sticky_clr,
    output logic                    busy
);

    localparam int unsigned CNT_W = 2;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BF16_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [FLAG_W-1:0]   flg_q, flg_d, sticky_q, sticky_d;
    logic                vld_q, vld_d;
    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     grant_id;
    logic                granted;

    assign req_ready = (state_q == StIdle) ? grant : '0;
    assign granted   = |req_ready;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .advance_i   (granted),
        .grant_o     (grant),
        .grant_id_o  (grant_id)
    );

    // FSM next state, operand capture, countdown and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        res_d   = res_q;
        flg_d   = flg_q;
        vld_d   = vld_q;
        unique case (state_q)
            StIdle: begin
                if (granted) begin
                    a_d     = req_a[grant_id*BF16_W +: BF16_W];
                    b_d     = req_b[grant_id*BF16_W +: BF16_W];
                    id_d    = grant_id;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    res_d   = mul_result;
                    flg_d   = mul_flags;
                    vld_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky accumulation; a clear beats a coincident handshake.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = '0;
        end else if (vld_q && rsp_ready) begin
            sticky_d = sticky_q | flg_q;
        end
    end

    // All state registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            vld_q    <= 1'b0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            vld_q    <= vld_d;
            sticky_q <= sticky_d;
        end
    end

    assign mul_a        = a_q;
    assign mul_b        = b_q;
    assign rsp_valid    = vld_q;
    assign rsp_id       = id_q;
    assign rsp_result   = res_q;
    assign rsp_flags    = flg_q;
    assign sticky_flags = sticky_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Bench: directed stimulus, a transaction-level model checked every cycle for
// the MUL_LAT=1 instance, and literal checks including a MUL_LAT=3 instance.
module tb_bf16_mul_arbiter;
    import bf16_pkg::*;

    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Mock multiplier: known pairs give true BF16 products, others a fixed scramble.
    function automatic logic [22:0] mock_mul(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3F80 && b == 16'h4000) return {16'h4000, 7'b0000000};
        if (a == 16'h7F80 && b == 16'h7F80) return {16'h7F80, 7'b0000010};
        return {a ^ {b[7:0], b[15:8]}, a[6:0] ^ b[13:7]};
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int oh2id(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- MUL_LAT=1 instance ----------------
    logic        rst_n;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic [15:0] mul_a, mul_b, mul_result, rsp_result;
    logic [6:0]  mul_flags, rsp_flags, sticky_flags;
    logic        rsp_valid, rsp_ready, sticky_clr, busy;
    logic [1:0]  rsp_id;

    assign {mul_result, mul_flags} = mock_mul(mul_a, mul_b);

    bf16_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_flags(mul_flags), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
        .busy(busy)
    );

    // ---------------- MUL_LAT=3 instance ----------------
    logic        rst3_n;
    logic [3:0]  v3, rdy3;
    logic [63:0] a3, b3;
    logic [15:0] ma3, mb3, mr3, res3;
    logic [6:0]  mf3, flg3, stk3;
    logic        vld3, busy3;
    logic [1:0]  id3;

    assign {mr3, mf3} = mock_mul(ma3, mb3);

    bf16_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .mul_a(ma3), .mul_b(mb3),
        .mul_result(mr3), .mul_flags(mf3), .rsp_valid(vld3),
        .rsp_ready(1'b1), .rsp_id(id3), .rsp_result(res3),
        .rsp_flags(flg3), .sticky_flags(stk3), .sticky_clr(1'b0),
        .busy(busy3)
    );

    // ---------------- transaction model for u_dut1 ----------------
    int          m_ptr, m_age, m_id;
    bit          m_busy;
    logic [15:0] m_a, m_b, m_res;
    logic [6:0]  m_flg, m_sticky;

    // Compare at the falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        int         w;
        logic [3:0] er;
        logic       ev;
        if (!rst_n) begin
            m_ptr = 0; m_age = 0; m_id = 0; m_busy = 0;
            m_a = '0; m_b = '0; m_res = '0; m_flg = '0; m_sticky = '0;
            chk("rst_ready", {28'd0, req_ready}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_mul_a", {16'd0, mul_a}, 32'd0);
            chk("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
            chk("rst_sticky", {25'd0, sticky_flags}, 32'd0);
        end else begin
            w  = m_busy ? -1 : pick(req_valid, m_ptr);
            er = (w < 0) ? 4'b0000 : (4'b0001 << w);
            ev = m_busy && (m_age >= LAT1 + 1);
            chk("m_req_ready", {28'd0, req_ready}, {28'd0, er});
            chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
            chk("m_mul_a", {16'd0, mul_a}, {16'd0, m_a});
            chk("m_mul_b", {16'd0, mul_b}, {16'd0, m_b});
            chk("m_rsp_result", {16'd0, rsp_result}, {16'd0, m_res});
            chk("m_rsp_flags", {25'd0, rsp_flags}, {25'd0, m_flg});
            chk("m_sticky", {25'd0, sticky_flags}, {25'd0, m_sticky});
            if (ev) chk("m_rsp_id", {30'd0, rsp_id}, m_id);
            if (sticky_clr) m_sticky = '0;
            else if (ev && rsp_ready) m_sticky = m_sticky | m_flg;
            if (m_busy) begin
                if (ev && rsp_ready) begin
                    m_busy = 0;
                end else begin
                    if (m_age == LAT1) {m_res, m_flg} = mock_mul(m_a, m_b);
                    m_age++;
                end
            end else if (w >= 0) begin
                m_busy = 1;
                m_age  = 1;
                m_id   = w;
                m_a    = req_a[w*16 +: 16];
                m_b    = req_b[w*16 +: 16];
                m_ptr  = (w + 1) % 4;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        for (int c = 0; c < 10 && req_ready == 4'b0000; c++) tick();
        chk(name, {31'd0, (req_ready != 4'b0000)}, 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        for (int c = 0; c < 10 && !rsp_valid; c++) tick();
        chk(name, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 20 && busy; c++) tick();
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int gids[$];
        int gcyc[$];
        int rids[$];
        int exp_ord[5];
        int k;
        logic [22:0] mx;
        exp_ord = '{0, 1, 2, 3, 0};

        rst_n = 0; rst3_n = 0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 0; sticky_clr = 0;
        v3 = '0; a3 = '0; b3 = '0;

        // 1: reset held for 3 cycles
        repeat (3) tick();
        chk("t1_ready", {28'd0, req_ready}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("t1_rsp_flags", {25'd0, rsp_flags}, 32'd0);
        chk("t1_mul_b", {16'd0, mul_b}, 32'd0);
        chk("t1_busy3", {31'd0, busy3}, 32'd0);
        rst_n = 1; rst3_n = 1;

        // 2: single op on requester 0
        tick();
        req_a[15:0] = 16'h3F80; req_b[15:0] = 16'h4000; req_valid = 4'b0001;
        rsp_ready = 1;
        #1;
        chk("t2_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("t2_not_yet", {31'd0, rsp_valid}, 32'd0);
        chk("t2_mul_a", {16'd0, mul_a}, 32'h3F80);
        tick();
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("t2_rsp_result", {16'd0, rsp_result}, 32'h4000);
        chk("t2_rsp_flags", {25'd0, rsp_flags}, 32'd0);
        tick();

        // 3: all requesters valid, fresh pointer
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'h1100 + 16'(i);
            req_b[i*16 +: 16] = 16'h2200 + 16'(i * 3);
        end
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 40 && gids.size() < 5; c++) begin
            if (req_ready != 4'b0000) begin
                gids.push_back(oh2id(req_ready));
                gcyc.push_back(c);
            end
            if (rsp_valid && rsp_ready) rids.push_back(int'(rsp_id));
            tick();
        end
        req_valid = 4'b0000;
        chk("t3_grant_count", gids.size(), 32'd5);
        for (int i = 0; i < gids.size(); i++) begin
            chk("t3_grant_order", gids[i], exp_ord[i]);
            if (i > 0) chk("t3_grant_gap", gcyc[i] - gcyc[i-1], 32'd3);
        end
        chk("t3_rsp_count", rids.size(), 32'd4);
        for (int i = 0; i < rids.size() && i < 5; i++) chk("t3_rsp_order", rids[i], exp_ord[i]);
        wait_idle();

        // 4: backpressure on the response channel
        rsp_ready = 0;
        req_a[47:32] = 16'h1234; req_b[47:32] = 16'h0F0F;
        req_a[63:48] = 16'h4321; req_b[63:48] = 16'h5A5A;
        req_valid = 4'b0100;
        #1;
        wait_grant("t4_grant_timeout");
        chk("t4_grant", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = 4'b1000;
        wait_rsp("t4_rsp_timeout");
        mx = mock_mul(16'h1234, 16'h0F0F);
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t4_hold_result", {16'd0, rsp_result}, {16'd0, mx[22:7]});
            chk("t4_hold_id", {30'd0, rsp_id}, 32'd2);
            chk("t4_no_grant", {28'd0, req_ready}, 32'd0);
            chk("t4_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        rsp_ready = 1;
        tick();
        chk("t4_released", {31'd0, rsp_valid}, 32'd0);
        chk("t4_next_grant", {28'd0, req_ready}, 32'h8);
        tick();
        req_valid = 4'b0000;
        wait_idle();

        // 5: exception flags and sticky behaviour
        sticky_clr = 1;
        tick();
        sticky_clr = 0;
        chk("t5_clr_idle", {25'd0, sticky_flags}, 32'd0);
        req_a[47:32] = 16'h7F80; req_b[47:32] = 16'h7F80;
        req_valid = 4'b0100;
        #1;
        wait_grant("t5_grant_timeout");
        tick();
        req_valid = 4'b0000;
        wait_rsp("t5_rsp_timeout");
        chk("t5_rsp_flags", {25'd0, rsp_flags}, 32'h02);
        chk("t5_rsp_result", {16'd0, rsp_result}, {16'd0, BF16_PINF});
        tick();
        chk("t5_sticky", {25'd0, sticky_flags}, 32'h02);
        rsp_ready = 0;
        req_a[15:0] = 16'h7F80; req_b[15:0] = 16'h7F80;
        req_valid = 4'b0001;
        #1;
        wait_grant("t5_grant2_timeout");
        tick();
        req_valid = 4'b0000;
        wait_rsp("t5_rsp2_timeout");
        chk("t5_sticky_kept", {25'd0, sticky_flags}, 32'h02);
        rsp_ready = 1; sticky_clr = 1;
        tick();
        sticky_clr = 0;
        chk("t5_clr_wins", {25'd0, sticky_flags}, 32'd0);
        chk("t5_rsp_done", {31'd0, rsp_valid}, 32'd0);

        // 6: MUL_LAT=3 latency, then async reset during WAIT
        a3[31:16] = 16'h3F80; b3[31:16] = 16'h4000;
        v3 = 4'b0010;
        #1;
        chk("t6_grant", {28'd0, rdy3}, 32'h2);
        tick();
        v3 = 4'b0000;
        k = 1;
        while (!vld3 && k < 10) begin
            tick();
            k++;
        end
        chk("t6_latency", k, 32'd4);
        chk("t6_result", {16'd0, res3}, 32'h4000);
        chk("t6_id", {30'd0, id3}, 32'd1);
        tick();
        a3[47:32] = 16'h1357; b3[47:32] = 16'h2468;
        v3 = 4'b0100;
        #1;
        chk("t6_grant2", {28'd0, rdy3}, 32'h4);
        tick();
        v3 = 4'b0000;
        tick();
        #2;
        rst3_n = 0;
        #1;
        chk("t6_rst_valid", {31'd0, vld3}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy3}, 32'd0);
        chk("t6_rst_mul_a", {16'd0, ma3}, 32'd0);
        tick();
        tick();
        rst3_n = 1;
        for (int c = 0; c < 6; c++) begin
            chk("t6_no_rsp", {31'd0, vld3}, 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) a3[i*16 +: 16] = 16'h0100 + 16'(i);
        v3 = 4'b1111;
        #1;
        chk("t6_ptr_reset", {28'd0, rdy3}, 32'h1);
        tick();
        v3 = 4'b0000;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
